// File: rtl/tdm_demux8_pkg.sv
// Shared types and sizing for the 8-slot TDM demultiplexer.
package tdm_demux8_pkg;

  localparam int unsigned SLOT_W   = 3;
  localparam int unsigned N_SLOTS  = 8;
  localparam int unsigned SHADOW_W = N_SLOTS - 1;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  typedef logic [SLOT_W-1:0] slot_t;

  localparam slot_t FIRST_SLOT = slot_t'(0);
  localparam slot_t NEXT_SLOT  = slot_t'(1);

  // Slot counter advance; modulo-8 wrap falls out of the 3-bit width.
  function automatic slot_t slot_inc(input slot_t s);
    return s + slot_t'(1);
  endfunction

endpackage

// File: rtl/demux1x8.sv
// One-hot write-enable decoder for the frame shadow register.
module demux1x8
  import tdm_demux8_pkg::*;
(
  input  logic               en,
  input  logic [SLOT_W-1:0]  slot,
  output logic [N_SLOTS-1:0] we_c
);

  always_comb begin
    we_c = '0;
    if (en) begin
      we_c[slot] = 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux8.sv
// Serial TDM demultiplexer: aligns on sync and presents each 8-slot frame in parallel.
module tdm_demux8
  import tdm_demux8_pkg::*;
#(
  parameter bit SYNC_CHECK = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din,
  input  logic               sync,
  input  logic               en,
  output logic [N_SLOTS-1:0] y,
  output logic [SLOT_W-1:0]  slot,
  output logic               frame_valid,
  output logic               locked,
  output logic               sync_err
);

  state_t              state;
  state_t              state_nxt;
  slot_t               slot_nxt;
  slot_t               wr_slot_c;
  logic                wr_c;
  logic                err_nxt;
  logic [N_SLOTS-1:0]  we_c;
  logic [SHADOW_W-1:0] shadow;

  // Framing decisions; a write to the last slot is what completes a frame.
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    wr_c      = 1'b0;
    wr_slot_c = slot;
    err_nxt   = 1'b0;
    if (en) begin
      case (state)
        HUNT: begin
          if (sync) begin
            wr_c      = 1'b1;
            wr_slot_c = FIRST_SLOT;
            slot_nxt  = NEXT_SLOT;
            state_nxt = LOCK;
          end
        end
        LOCK: begin
          if (sync && (slot != FIRST_SLOT)) begin
            // Early sync: drop the partial frame and realign on this bit.
            err_nxt   = 1'b1;
            wr_c      = 1'b1;
            wr_slot_c = FIRST_SLOT;
            slot_nxt  = NEXT_SLOT;
          end else if (!sync && (slot == FIRST_SLOT) && SYNC_CHECK) begin
            err_nxt   = 1'b1;
            slot_nxt  = FIRST_SLOT;
            state_nxt = HUNT;
          end else begin
            wr_c     = 1'b1;
            slot_nxt = slot_inc(slot);
          end
        end
        default: begin
          state_nxt = HUNT;
          slot_nxt  = FIRST_SLOT;
        end
      endcase
    end
  end

  demux1x8 u_demux (
    .en   (wr_c),
    .slot (wr_slot_c),
    .we_c (we_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= HUNT;
      slot        <= FIRST_SLOT;
      y           <= '0;
      shadow      <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      locked      <= 1'b0;
    end else begin
      state       <= state_nxt;
      slot        <= slot_nxt;
      locked      <= (state_nxt == LOCK);
      sync_err    <= err_nxt;
      frame_valid <= we_c[N_SLOTS-1];
      if (we_c[N_SLOTS-1]) begin
        y <= {din, shadow};
      end
      for (int unsigned k = 0; k < SHADOW_W; k++) begin
        if (we_c[k]) begin
          shadow[k] <= din;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux8.sv
// Randomized and directed checks of tdm_demux8 (both SYNC_CHECK settings) against a frame-level model.
module tb_tdm_demux8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       sync = 1'b0;
  logic       en = 1'b0;
  logic [7:0] y_a, y_b;
  logic [2:0] slot_a, slot_b;
  logic       fv_a, fv_b, lk_a, lk_b, er_a, er_b;
  logic [14:0] obs_a, obs_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  tdm_demux8 #(.SYNC_CHECK(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din), .sync(sync), .en(en),
    .y(y_a), .slot(slot_a), .frame_valid(fv_a), .locked(lk_a), .sync_err(er_a)
  );

  tdm_demux8 #(.SYNC_CHECK(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din), .sync(sync), .en(en),
    .y(y_b), .slot(slot_b), .frame_valid(fv_b), .locked(lk_b), .sync_err(er_b)
  );

  assign obs_a = {y_a, slot_a, fv_a, lk_a, er_a};
  assign obs_b = {y_b, slot_b, fv_b, lk_b, er_b};

  // Frame-level reference: index 0 models SYNC_CHECK=1, index 1 models SYNC_CHECK=0.
  bit       m_lock [2];
  int       m_pos  [2];
  bit       m_part [2][8];
  bit [7:0] m_y    [2];
  bit       m_fv   [2];
  bit       m_err  [2];

  task automatic model_step(input int i, input bit sc, input bit r,
                            input bit d, input bit s, input bit e);
    int v;
    m_fv[i]  = 1'b0;
    m_err[i] = 1'b0;
    if (!r) begin
      m_lock[i] = 1'b0;
      m_pos[i]  = 0;
      m_y[i]    = 8'h00;
      for (int k = 0; k < 8; k++) m_part[i][k] = 1'b0;
    end else if (e) begin
      if (!m_lock[i]) begin
        if (s) begin
          m_part[i][0] = d;
          m_pos[i]     = 1;
          m_lock[i]    = 1'b1;
        end
      end else if (s && m_pos[i] != 0) begin
        m_err[i]     = 1'b1;
        m_part[i][0] = d;
        m_pos[i]     = 1;
      end else if (!s && m_pos[i] == 0 && sc) begin
        m_err[i]  = 1'b1;
        m_lock[i] = 1'b0;
      end else begin
        m_part[i][m_pos[i]] = d;
        if (m_pos[i] == 7) begin
          v = 0;
          for (int k = 0; k < 8; k++) v += int'(m_part[i][k]) * (1 << k);
          m_y[i]   = 8'(v);
          m_fv[i]  = 1'b1;
          m_pos[i] = 0;
        end else begin
          m_pos[i] = m_pos[i] + 1;
        end
      end
    end
  endtask

  function automatic logic [14:0] exp_vec(input int i);
    return {m_y[i], 3'(m_pos[i]), m_fv[i], m_lock[i], m_err[i]};
  endfunction

  task automatic drive(input bit r, input bit d, input bit s, input bit e);
    @(negedge clk);
    rst_n = r;
    din   = d;
    sync  = s;
    en    = e;
    model_step(0, 1'b1, r, d, s, e);
    model_step(1, 1'b0, r, d, s, e);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({obs_a, obs_b} !== 30'h0) begin
      n_bad++;
      $display("FAIL reset_state: got %h/%h want 0000/0000", obs_a, obs_b);
    end
    n_cmp++;
    if ({obs_a, obs_b} !== {exp_vec(0), exp_vec(1)}) begin
      n_bad++;
      $display("FAIL reset_model: got %h/%h want %h/%h", obs_a, obs_b, exp_vec(0), exp_vec(1));
    end
  endtask

  task automatic test_single_frame();
    bit [7:0] pat = 8'h4D;
    int pulses = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, pat[k], k == 0, 1'b1);
      if (fv_a) pulses++;
      n_cmp++;
      if ({obs_a, obs_b} !== {exp_vec(0), exp_vec(1)}) begin
        n_bad++;
        $display("FAIL single_frame k=%0d: got %h/%h want %h/%h", k, obs_a, obs_b, exp_vec(0), exp_vec(1));
      end
    end
    n_cmp++;
    if ({y_a, lk_a} !== {8'h4D, 1'b1} || pulses !== 1) begin
      n_bad++;
      $display("FAIL single_frame_result: got y=%h locked=%b pulses=%0d want y=4d locked=1 pulses=1", y_a, lk_a, pulses);
    end
  endtask

  task automatic test_back_to_back();
    bit [7:0] frames [2] = '{8'hA5, 8'h3C};
    bit [7:0] pat;
    int       p_cyc [2] = '{0, 0};
    bit [7:0] got   [2] = '{8'h00, 8'h00};
    int       np = 0;
    for (int f = 0; f < 2; f++) begin
      pat = frames[f];
      for (int k = 0; k < 8; k++) begin
        drive(1'b1, pat[k], k == 0, 1'b1);
        if (fv_a && np < 2) begin
          p_cyc[np] = cyc;
          got[np]   = y_a;
          np++;
        end
        n_cmp++;
        if ({obs_a, obs_b} !== {exp_vec(0), exp_vec(1)}) begin
          n_bad++;
          $display("FAIL back_to_back f=%0d k=%0d: got %h/%h want %h/%h", f, k, obs_a, obs_b, exp_vec(0), exp_vec(1));
        end
      end
    end
    n_cmp++;
    if (np !== 2 || (p_cyc[1] - p_cyc[0]) !== 8 || got[0] !== 8'hA5 || got[1] !== 8'h3C) begin
      n_bad++;
      $display("FAIL back_to_back_pulses: got n=%0d gap=%0d y=%h,%h want n=2 gap=8 y=a5,3c",
               np, p_cyc[1] - p_cyc[0], got[0], got[1]);
    end
  endtask

  task automatic test_en_toggle();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b1, k == 0, 1'b1);
      n_cmp++;
      if ({obs_a, obs_b} !== {exp_vec(0), exp_vec(1)}) begin
        n_bad++;
        $display("FAIL en_toggle_on k=%0d: got %h/%h want %h/%h", k, obs_a, obs_b, exp_vec(0), exp_vec(1));
      end
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if ({fv_a, fv_b, er_a, er_b} !== 4'b0000 || {obs_a, obs_b} !== {exp_vec(0), exp_vec(1)}) begin
        n_bad++;
        $display("FAIL en_toggle_off k=%0d: got %h/%h want %h/%h", k, obs_a, obs_b, exp_vec(0), exp_vec(1));
      end
    end
    n_cmp++;
    if (y_a !== 8'hFF) begin
      n_bad++;
      $display("FAIL en_toggle_y: got %h want ff", y_a);
    end
  endtask

  task automatic test_early_sync();
    bit [7:0] pat = 8'h0F;
    int errs = 0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), k == 0, 1'b1);
      if (er_a) errs++;
      n_cmp++;
      if ({obs_a, obs_b} !== {exp_vec(0), exp_vec(1)} || y_a !== 8'hFF) begin
        n_bad++;
        $display("FAIL early_sync_partial k=%0d: got %h/%h want %h/%h", k, obs_a, obs_b, exp_vec(0), exp_vec(1));
      end
    end
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, pat[k], k == 0, 1'b1);
      if (er_a) errs++;
      n_cmp++;
      if ({obs_a, obs_b} !== {exp_vec(0), exp_vec(1)}) begin
        n_bad++;
        $display("FAIL early_sync_frame k=%0d: got %h/%h want %h/%h", k, obs_a, obs_b, exp_vec(0), exp_vec(1));
      end
      if (k < 7) begin
        n_cmp++;
        if (y_a !== 8'hFF) begin
          n_bad++;
          $display("FAIL early_sync_hold k=%0d: got %h want ff", k, y_a);
        end
      end
    end
    n_cmp++;
    if (y_a !== 8'h0F || errs !== 1) begin
      n_bad++;
      $display("FAIL early_sync_result: got y=%h errs=%0d want y=0f errs=1", y_a, errs);
    end
  endtask

  task automatic test_missing_sync();
    bit [7:0] pat = 8'($urandom());
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if ({er_a, lk_a, slot_a, er_b, lk_b, slot_b} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1}) begin
      n_bad++;
      $display("FAIL missing_sync: got a err=%b lk=%b slot=%0d b err=%b lk=%b slot=%0d want 1 0 0 / 0 1 1",
               er_a, lk_a, slot_a, er_b, lk_b, slot_b);
    end
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, pat[k], k == 0, 1'b1);
      n_cmp++;
      if ({obs_a, obs_b} !== {exp_vec(0), exp_vec(1)}) begin
        n_bad++;
        $display("FAIL relock k=%0d: got %h/%h want %h/%h", k, obs_a, obs_b, exp_vec(0), exp_vec(1));
      end
    end
    n_cmp++;
    if ({lk_a, y_a} !== {1'b1, pat}) begin
      n_bad++;
      $display("FAIL relock_result: got lk=%b y=%h want lk=1 y=%h", lk_a, y_a, pat);
    end
  endtask

  task automatic test_reset_mid_frame();
    int pulses = 0;
    for (int k = 0; k < 5; k++) drive(1'b1, 1'($urandom_range(0, 1)), k == 0, 1'b1);
    n_cmp++;
    if (slot_a !== 3'd5) begin
      n_bad++;
      $display("FAIL mid_frame_slot: got %0d want 5", slot_a);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if ({y_a, slot_a, lk_a, fv_a, er_a} !== 15'h0) begin
      n_bad++;
      $display("FAIL mid_frame_reset: got y=%h slot=%0d lk=%b fv=%b err=%b want all 0", y_a, slot_a, lk_a, fv_a, er_a);
    end
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      if (fv_a || fv_b || er_a || er_b) pulses++;
      n_cmp++;
      if ({obs_a, obs_b} !== {exp_vec(0), exp_vec(1)} || lk_a !== 1'b0) begin
        n_bad++;
        $display("FAIL post_reset_hunt k=%0d: got %h/%h want %h/%h", k, obs_a, obs_b, exp_vec(0), exp_vec(1));
      end
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++;
      $display("FAIL post_reset_pulses: got %0d want 0", pulses);
    end
  endtask

  task automatic test_random();
    bit r, d, s, e;
    int ec = 0;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 199) != 0);
      e = ($urandom_range(0, 3) != 0);
      d = 1'($urandom_range(0, 1));
      s = ((ec % 8) == 0) ^ ($urandom_range(0, 29) == 0);
      if (e) ec++;
      drive(r, d, s, e);
      n_cmp++;
      if ({obs_a, obs_b} !== {exp_vec(0), exp_vec(1)}) begin
        n_bad++;
        $display("FAIL random n=%0d: got %h/%h want %h/%h", n, obs_a, obs_b, exp_vec(0), exp_vec(1));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_en_toggle();
    test_early_sync();
    test_missing_sync();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux8.md
TDM_DEMUX8 -- requirements
Module: tdm_demux8

Interface
REQ-001 Parameter SYNC_CHECK, default 1: 1 = a missing sync at slot 0 is an error; 0 = missing sync at slot 0 is ignored.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 din  input  1  serial time-multiplexed data bit, slot order 0..7.
REQ-005 sync  input  1  frame marker, high coincident with the slot-0 bit.
REQ-006 en  input  1  slot strobe; din/sync sampled only when en=1.
REQ-007 y  output  8  demultiplexed frame; y[k] = bit received in slot k.
REQ-008 slot  output  3  index of the slot the next en-qualified bit fills.
REQ-009 frame_valid  output  1  one-cycle pulse, y updated.
REQ-010 locked  output  1  high in LOCK state.
REQ-011 sync_err  output  1  one-cycle pulse on a framing error.

Function
REQ-012 The FSM SHALL have two states, HUNT and LOCK; all outputs registered.
REQ-013 Cycles with en=0 SHALL hold all state; frame_valid and sync_err SHALL be 0 in those cycles.
REQ-014 HUNT, en=1, sync=1: the block SHALL store din as shadow[0], set slot=1, and enter LOCK.
REQ-015 HUNT, en=1, sync=0: the bit SHALL be discarded; slot stays 0; no error pulse.
REQ-016 LOCK, en=1, 1<=slot<=6, sync=0: the block SHALL set shadow[slot]=din and slot=slot+1.
REQ-017 LOCK, en=1, slot=7, sync=0: y SHALL load {din, shadow[6:0]}, frame_valid SHALL pulse the next cycle, and slot SHALL wrap to 0.
REQ-018 Latency: y and frame_valid SHALL update on the edge sampling the slot-7 bit, visible the cycle after.
REQ-019 LOCK, en=1, slot=0, sync=1: the block SHALL store shadow[0]=din and set slot=1 (normal frame start).
REQ-020 LOCK, en=1, slot=0, sync=0, SYNC_CHECK=1: sync_err SHALL pulse, the bit SHALL be discarded, and the FSM SHALL go to HUNT with slot=0.
REQ-021 Same case with SYNC_CHECK=0: the bit SHALL be treated as slot 0 per REQ-019.
REQ-022 LOCK, en=1, sync=1, slot!=0 (early sync): sync_err SHALL pulse, the partial frame SHALL be discarded with y unchanged and no frame_valid, and the block SHALL re-align with shadow[0]=din, slot=1, staying in LOCK.
REQ-023 y SHALL change only via REQ-017; shadow bits of a discarded frame SHALL never reach y.
REQ-024 slot arithmetic SHALL be 3-bit modulo 8; no other wrap exists.

Reset
REQ-025 On a clk edge with rst_n=0, the block SHALL set state=HUNT, slot=0, y=8'h00, shadow=0, frame_valid=0, sync_err=0, and locked=0.
REQ-026 Reset mid-frame SHALL abandon the partial frame; no frame_valid or sync_err pulse follows reset.
REQ-027 The first en-qualified sample after rst_n rises SHALL be processed per HUNT rules.

Structure
REQ-028 A shared package SHALL hold the state enum (HUNT, LOCK), SLOT_W=3, and N_SLOTS=8.
REQ-029 One sub-module, demux1x8, SHALL decode slot into an 8-bit one-hot shadow write-enable gated by en; all remaining logic lives in tdm_demux8.

Verification
REQ-030 Reset, then 8 en-cycles with sync on the first and din=1,0,1,1,0,0,1,0 -> y=8'h4D, frame_valid single pulse, locked=1.
REQ-031 Two back-to-back frames 8'hA5 then 8'h3C with en=1 every cycle -> two frame_valid pulses exactly 8 cycles apart, y=8'hA5 then 8'h3C.
REQ-032 Frame 8'hFF with en toggling 1,0 -> y=8'hFF after 16 cycles; frame_valid=0 in all en=0 cycles.
REQ-033 Early sync at slot 4, then a full frame 8'h0F -> sync_err pulses once, y stays 8'h0F-prior value until the new frame, then y=8'h0F.
REQ-034 Locked, SYNC_CHECK=1, sync missing at slot 0 -> sync_err pulse, locked=0, slot=0; next sync relocks. Same stimulus with SYNC_CHECK=0 -> no error.
REQ-035 rst_n=0 at slot 5 of a frame -> y=8'h00, slot=0, locked=0, and no frame_valid pulse.
